// File: rtl/alu_types_pkg.sv
// Shared ALU types: sequencing states for the multi-cycle arithmetic blocks.
package alu_types_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/shift_left_logical.sv
// Combinational logical left shift; o_lost flags any set bit pushed past the MSB.
// Zero latency, no flow control.
module shift_left_logical #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_dat,
    input  logic [SW-1:0] i_shamt,
    output logic [N-1:0]  o_dat,
    output logic          o_lost
);

    logic [2*N-1:0] w_wide;

    assign w_wide = {{N{1'b0}}, i_dat} << i_shamt;
    assign o_dat  = w_wide[N-1:0];
    assign o_lost = |w_wide[2*N-1:N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned N x N shift-add multiplier keeping the low N bits; fixed N+1 edges accept-to-done.
// start is honoured only while ready=1; it is ignored during the run.
module shift_add_multiplier
    import alu_types_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] product,
    output logic         overflow
);

    localparam int              CW   = $clog2(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    mul_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_acc;
    logic          r_ovf;
    logic          r_done;
    logic          r_ready;

    logic [N-1:0]  w_shift;
    logic          w_lost;
    logic [N-1:0]  w_sum;
    logic          w_carry;
    logic          w_bit;

    shift_left_logical #(
        .N  (N),
        .SW (CW)
    ) u_shl (
        .i_dat   (r_a),
        .i_shamt (r_cnt),
        .o_dat   (w_shift),
        .o_lost  (w_lost)
    );

    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_shift};
    assign w_bit            = r_b[r_cnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Only partial products that are actually added may raise overflow.
                    if (w_bit) begin
                        r_acc <= w_sum;
                        if (w_lost || w_carry) begin
                            r_ovf <= 1'b1;
                        end
                    end
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign product  = r_acc;
    assign overflow = r_ovf;

endmodule
